// File: rtl/osd_text_writer.sv
// Renders 8x16 font ROM glyphs into a 128x32 OSD bitmap; clears it on request.
// Optional `OSD_DOUBLE_BUF_EN`: writes land in a shadow copy shown on i_vs rise.
module osd_text_writer #(
  parameter int FONT_AW = 12
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_clear,
  input  logic [7:0]         cmd_char,
  input  logic [3:0]         cmd_col,
  input  logic               cmd_line,
  input  logic               cmd_inv,
  output logic [FONT_AW-1:0] font_addr,
  input  logic [7:0]         font_data,
  input  logic               i_vs,
  output logic               busy,
  output logic [4095:0]      bitmap
);

  typedef enum logic [1:0] {IDLE, GLYPH, CLEAR} state_t;

  state_t        state, state_nxt;
  logic [4:0]    cnt;
  logic [7:0]    char_q;
  logic [3:0]    col_q;
  logic          line_q;
  logic          inv_q;
  logic [4095:0] work;
  logic [3:0]    g_row;
  logic [11:0]   base;
  logic          wr_en;

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;

  // ROM data lags the address by one cycle, so the row written trails cnt by one.
  assign g_row = cnt[3:0] - 4'd1;
  assign base  = {line_q, g_row, 7'd120} - {5'd0, col_q, 3'd0};
  assign wr_en = ((state == GLYPH) && (cnt != 5'd0)) || (state == CLEAR);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = cmd_clear ? CLEAR : GLYPH;
      GLYPH:   if (cnt == 5'd16) state_nxt = IDLE;
      CLEAR:   if (cnt == 5'd31) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      char_q    <= '0;
      col_q     <= '0;
      line_q    <= 1'b0;
      inv_q     <= 1'b0;
      font_addr <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          cnt    <= '0;
          char_q <= cmd_char;
          col_q  <= cmd_col;
          line_q <= cmd_line;
          inv_q  <= cmd_inv;
          if (!cmd_clear) font_addr <= FONT_AW'({cmd_char, 4'd0});
        end
        GLYPH: begin
          cnt <= cnt + 5'd1;
          if (cnt < 5'd15) font_addr <= FONT_AW'({char_q, cnt[3:0] + 4'd1});
        end
        CLEAR:   cnt <= cnt + 5'd1;
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
    end else if ((state == GLYPH) && (cnt != 5'd0)) begin
      work[base +: 8] <= font_data ^ {8{inv_q}};
    end else if (state == CLEAR) begin
      work[{cnt, 7'd0} +: 128] <= '0;
    end
  end

`ifdef OSD_DOUBLE_BUF_EN
  logic vs_q;
  logic dirty;

  // Copy only between commands so a half-drawn glyph never reaches the screen.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q   <= 1'b0;
      dirty  <= 1'b0;
      bitmap <= '0;
    end else begin
      vs_q <= i_vs;
      if (wr_en) begin
        dirty <= 1'b1;
      end else if ((state == IDLE) && dirty && i_vs && !vs_q) begin
        bitmap <= work;
        dirty  <= 1'b0;
      end
    end
  end
`else
  logic unused_vs;
  logic unused_wr;
  assign unused_vs = i_vs;
  assign unused_wr = wr_en;
  assign bitmap    = work;
`endif

endmodule
